// File: rtl/result_reader_pkg.sv
// result_reader_pkg: shared types and sizing helpers for the result readback path.
//   state_e        - readback FSM state encoding (3 bits, 6 states)
//   bytes_per_word - bytes carried by one SRAM word
//   cnt_w          - width of a counter that must hold the value n
package result_reader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_SEND,
        S_NEXT,
        S_FIN
    } state_e;

    function automatic int bytes_per_word(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    // Sizing for the default configuration.
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_NUM_WORDS  = 16;
    localparam int DEF_RY_TIMEOUT = 15;
    localparam int BYTES_PER_WORD = bytes_per_word(DEF_DATA_W);
    localparam int WCNT_W         = cnt_w(DEF_NUM_WORDS);
    localparam int TO_W           = cnt_w(DEF_RY_TIMEOUT);

endpackage

// File: rtl/result_reader_word_serializer.sv
// result_reader_word_serializer: turns one SRAM word into a LSB-first byte stream.
//   clk, rst      - clock, synchronous active-low reset
//   load_i/word_i - capture a new word (starts a fresh byte sequence)
//   dout_o, dout_valid_o, dout_ready_i - valid/ready byte stream
//   last_o        - high in the cycle the final byte of the word transfers
module result_reader_word_serializer
    import result_reader_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [DATA_W-1:0] word_i,
    output logic [7:0]        dout_o,
    output logic              dout_valid_o,
    input  logic              dout_ready_i,
    output logic              last_o
);
    localparam int BPW  = bytes_per_word(DATA_W);
    localparam int BC_W = cnt_w(BPW - 1);

    logic [DATA_W-1:0] shift_q;
    logic [BC_W-1:0]   byte_cnt_q;
    logic              valid_q;
    logic              xfer;

    assign xfer         = valid_q & dout_ready_i;
    assign last_o       = xfer && (byte_cnt_q == BC_W'(BPW - 1));
    assign dout_o       = shift_q[7:0];
    assign dout_valid_o = valid_q;

    // Shift only on a transfer, so the byte on dout_o is held under backpressure.
    always_ff @(posedge clk) begin
        if (!rst) begin
            shift_q    <= '0;
            byte_cnt_q <= '0;
            valid_q    <= 1'b0;
        end else if (load_i) begin
            shift_q    <= word_i;
            byte_cnt_q <= '0;
            valid_q    <= 1'b1;
        end else if (xfer) begin
            shift_q <= shift_q >> 8;
            if (last_o) begin
                byte_cnt_q <= '0;
                valid_q    <= 1'b0;
            end else begin
                byte_cnt_q <= byte_cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/result_reader.sv
// result_reader: reads NUM_WORDS result words from SRAM starting at base_addr and
// streams them out as bytes (LSB first per word).
//   clk, rst              - clock, synchronous active-low reset
//   start, base_addr      - begin a readback (accepted only when idle)
//   cs_n, we_n, address   - SRAM control (registered; we_n is always high)
//   ry, read_data         - SRAM ready and read data
//   dout, dout_valid, dout_ready - output byte stream
//   busy, done, err       - status: busy window, end pulse, sticky ry timeout
module result_reader
    import result_reader_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int NUM_WORDS  = 16,
    parameter int RY_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              cs_n,
    output logic              we_n,
    output logic [ADDR_W-1:0] address,
    input  logic              ry,
    input  logic [DATA_W-1:0] read_data,
    output logic [7:0]        dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int WC_W = cnt_w(NUM_WORDS);
    localparam int TO_W = cnt_w(RY_TIMEOUT);

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [WC_W-1:0]   word_cnt_q;
    logic [TO_W-1:0]   to_cnt_q;
    logic              cs_n_q, busy_q, done_q, err_q;
    logic              load, last;

    assign load    = (state_q == S_WAIT) && ry;
    assign cs_n    = cs_n_q;
    assign we_n    = 1'b1;
    assign address = addr_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

    result_reader_word_serializer #(.DATA_W(DATA_W)) u_ser (
        .clk          (clk),
        .rst          (rst),
        .load_i       (load),
        .word_i       (read_data),
        .dout_o       (dout),
        .dout_valid_o (dout_valid),
        .dout_ready_i (dout_ready),
        .last_o       (last)
    );

    // cs_n is set alongside each transition into/out of the SRAM access window
    // so it is low exactly for the REQ and WAIT cycles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            word_cnt_q <= '0;
            to_cnt_q   <= '0;
            cs_n_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: if (start) begin
                    addr_q     <= base_addr;
                    word_cnt_q <= '0;
                    err_q      <= 1'b0;
                    busy_q     <= 1'b1;
                    cs_n_q     <= 1'b0;
                    state_q    <= S_REQ;
                end
                S_REQ: begin
                    to_cnt_q <= '0;
                    state_q  <= S_WAIT;
                end
                S_WAIT: begin
                    if (ry) begin
                        cs_n_q  <= 1'b1;
                        state_q <= S_SEND;
                    end else if (to_cnt_q == TO_W'(RY_TIMEOUT - 1)) begin
                        // Abandon the whole readback; nothing of this word is sent.
                        err_q   <= 1'b1;
                        cs_n_q  <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= S_FIN;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                S_SEND: if (last) state_q <= S_NEXT;
                S_NEXT: begin
                    word_cnt_q <= word_cnt_q + 1'b1;
                    addr_q     <= addr_q + 1'b1;
                    if (word_cnt_q == WC_W'(NUM_WORDS - 1)) begin
                        done_q  <= 1'b1;
                        state_q <= S_FIN;
                    end else begin
                        cs_n_q  <= 1'b0;
                        state_q <= S_REQ;
                    end
                end
                S_FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
